// File: rtl/spi_master_byte_pkg.sv
// Shared definitions for the byte SPI master: state encoding and default sizing.
// Imported by the top module and by its divider sub-module.
package spi_master_byte_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_TRAIL = 3'd4
    } spi_state_e;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_CLK_DIV = 4;

endpackage

// File: rtl/spi_master_byte_tick_gen.sv
// SCK half-period divider: counts 0..CLK_DIV-1 while enabled and flags the last count.
// A synchronous clear restarts the count whenever the owning FSM changes state.
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;

    assign tick = (div_cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the signal unassigned (no latch).
        div_cnt_d = div_cnt_q + 1'b1;
        if (clr || !en || tick) begin
            div_cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_byte.sv
// Byte-oriented SPI master, mode 0, MSB first, with start/busy/done handshake.
// Every non-idle state lasts exactly CLK_DIV cycles of clk.
module spi_master_byte
    import spi_master_byte_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int               BIT_W    = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    spi_state_e        state_q,   state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] tx_sr_q,   tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q,   rx_sr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              sck_q,     sck_d;
    logic              cs_n_q,    cs_n_d;
    logic              done_q,    done_d;
    logic              tick;

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != ST_IDLE),
        .clr  (state_d != state_q),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        sck_d     = sck_q;
        cs_n_d    = cs_n_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tx_sr_d   = tx_data;
                    cs_n_d    = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = ST_LEAD;
                end
            end
            ST_LEAD, ST_LOW: begin
                if (tick) begin
                    state_d = ST_HIGH;
                    sck_d   = 1'b1;
                    rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    sck_d = 1'b0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_TRAIL;
                    end else begin
                        state_d   = ST_LOW;
                        tx_sr_d   = {tx_sr_q[DATA_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_TRAIL: begin
                if (tick) begin
                    state_d   = ST_IDLE;
                    cs_n_d    = 1'b1;
                    done_d    = 1'b1;
                    rx_data_d = rx_sr_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            sck_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            sck_q     <= sck_d;
            cs_n_q    <= cs_n_d;
            done_q    <= done_d;
        end
    end

    // The shift register MSB is the line itself, so mosi holds its last bit after a transfer.
    assign mosi    = tx_sr_q[DATA_W-1];
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sck     = sck_q;
    assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_byte.sv
// Scoreboard bench for spi_master_byte: 8-bit/div-4 and 16-bit/div-2 instances.
// Stimulus pushes expected completions; per-instance monitors pop them on each done.
module tb_spi_master_byte;

    typedef struct {
        logic [15:0] data;
        int          done_cyc;
        int          rises;
        int          cs_low;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    // 8-bit instance
    logic        start = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        busy, done, sck, mosi, miso, cs_n;
    logic [7:0]  rx_data;
    logic        slave_en = 1'b0;
    logic [7:0]  slave_pat = 8'h00;
    logic        miso_s = 1'b0;
    int          sidx = 0;
    int          done_cnt = 0;
    exp_t        q8[$];

    // 16-bit instance (loopback)
    logic        start16 = 1'b0;
    logic [15:0] tx16 = 16'h0000;
    logic        busy16, done16, sck16, mosi16, cs_n16;
    logic [15:0] rx16;
    exp_t        q16[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign miso = slave_en ? miso_s : mosi;

    spi_master_byte #(.DATA_W(8), .CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .busy(busy),
        .done(done), .rx_data(rx_data), .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    spi_master_byte #(.DATA_W(16), .CLK_DIV(2)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .tx_data(tx16), .busy(busy16),
        .done(done16), .rx_data(rx16), .sck(sck16), .mosi(mosi16), .miso(mosi16), .cs_n(cs_n16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Slave drives MSB when selected, then the next bit on each falling sck.
    always @(negedge cs_n) begin
        sidx   = 7;
        miso_s = slave_pat[7];
    end
    always @(negedge sck) begin
        if (!cs_n && sidx > 0) begin
            sidx   = sidx - 1;
            miso_s = slave_pat[sidx];
        end
    end

    // Monitor for the 8-bit instance.
    int  rises8 = 0, cs_low8 = 0;
    logic sck_prev8 = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            rises8 = 0; cs_low8 = 0;
        end else begin
            if (sck && !sck_prev8) rises8++;
            if (!cs_n) cs_low8++;
            if (done) begin
                exp_t e;
                done_cnt++;
                check("sb8_expected_done", 32'(q8.size() > 0), 32'd1);
                if (q8.size() > 0) begin
                    e = q8.pop_front();
                    check("rx_data8", 32'(rx_data), 32'(e.data[7:0]));
                    check("done_cycle8", 32'(cyc), 32'(e.done_cyc));
                    check("sck_rises8", 32'(rises8), 32'(e.rises));
                    check("cs_low8", 32'(cs_low8), 32'(e.cs_low));
                end
                rises8 = 0; cs_low8 = 0;
            end
        end
        sck_prev8 = sck;
    end

    // Monitor for the 16-bit instance.
    int  rises16 = 0, cs_low16 = 0;
    logic sck_prev16 = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            rises16 = 0; cs_low16 = 0;
        end else begin
            if (sck16 && !sck_prev16) rises16++;
            if (!cs_n16) cs_low16++;
            if (done16) begin
                exp_t e;
                check("sb16_expected_done", 32'(q16.size() > 0), 32'd1);
                if (q16.size() > 0) begin
                    e = q16.pop_front();
                    check("rx_data16", 32'(rx16), 32'(e.data));
                    check("done_cycle16", 32'(cyc), 32'(e.done_cyc));
                    check("sck_rises16", 32'(rises16), 32'(e.rises));
                    check("cs_low16", 32'(cs_low16), 32'(e.cs_low));
                end
                rises16 = 0; cs_low16 = 0;
            end
        end
        sck_prev16 = sck16;
    end

    // Called at a negedge: start is accepted on the next posedge, done follows 68 edges later.
    task automatic push8(input logic [7:0] d, input int extra);
        exp_t e;
        e.data     = {8'h00, d};
        e.done_cyc = cyc + 1 + 68 + extra;
        e.rises    = 8;
        e.cs_low   = 68;
        q8.push_back(e);
    endtask

    task automatic wait_done8(input string name, input int max);
        bit ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int busy_drops;
        int mosi_high;
        int dc;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rx", 32'(rx_data), 32'd0);
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Loopback A5
        tx_data = 8'hA5; start = 1'b1; push8(8'hA5, 0);
        @(negedge clk); start = 1'b0;
        wait_done8("loop_a5", 200);
        repeat (3) @(negedge clk);
        check("mosi_hold_lsb", 32'(mosi), 32'd1);

        // Slave drives 3C, master sends 00
        slave_en = 1'b1; slave_pat = 8'h3C;
        tx_data = 8'h00; start = 1'b1; push8(8'h3C, 0);
        @(negedge clk); start = 1'b0;
        mosi_high = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (!cs_n && mosi) mosi_high++;
            @(negedge clk);
        end
        check("slave_mosi_low", 32'(mosi_high), 32'd0);
        check("slave_done_seen", 32'(done), 32'd1);
        slave_en = 1'b0;
        repeat (2) @(negedge clk);

        // Start pulses while busy are ignored
        dc = done_cnt;
        tx_data = 8'h5A; start = 1'b1; push8(8'h5A, 0);
        @(negedge clk); start = 1'b0;
        busy_drops = 0;
        for (int k = 1; k < 200 && !done; k++) begin
            if (!busy) busy_drops++;
            if (k == 10 || k == 40) begin start = 1'b1; tx_data = 8'hFF; end
            else start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_held", 32'(busy_drops), 32'd0);
        repeat (100) @(negedge clk);
        check("single_done", 32'(done_cnt - dc), 32'd1);
        check("idle_after", 32'(busy), 32'd0);

        // start held: back-to-back 81 then 7E
        tx_data = 8'h81; start = 1'b1;
        push8(8'h81, 0); push8(8'h7E, 69);
        @(negedge clk); tx_data = 8'h7E;
        wait_done8("b2b_first", 200);
        check("b2b_cs_high_in_done", 32'(cs_n), 32'd1);
        @(negedge clk);
        check("b2b_cs_low_again", 32'(cs_n), 32'd0);
        check("b2b_done_one_cycle", 32'(done), 32'd0);
        start = 1'b0;
        wait_done8("b2b_second", 200);
        repeat (2) @(negedge clk);

        // Reset mid-transfer
        dc = done_cnt;
        tx_data = 8'hC3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_cs_n", 32'(cs_n), 32'd1);
        check("midrst_sck", 32'(sck), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rx", 32'(rx_data), 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (100) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt - dc), 32'd0);
        tx_data = 8'h96; start = 1'b1; push8(8'h96, 0);
        @(negedge clk); start = 1'b0;
        wait_done8("after_rst", 200);
        repeat (2) @(negedge clk);

        // 16-bit, CLK_DIV=2 loopback
        begin
            exp_t e;
            bit ok = 1'b0;
            e.data = 16'hBEEF; e.done_cyc = cyc + 1 + 66; e.rises = 16; e.cs_low = 66;
            q16.push_back(e);
            tx16 = 16'hBEEF; start16 = 1'b1;
            @(negedge clk); start16 = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (done16) begin ok = 1'b1; break; end
            end
            if (!ok) check("beef_timeout", 32'd0, 32'd1);
        end
        repeat (3) @(negedge clk);

        check("sb8_drained", 32'(q8.size()), 32'd0);
        check("sb16_drained", 32'(q16.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
